// File: rtl/csa_operand_sequencer.sv
// csa_operand_sequencer
// Feeds a 9-operand combinational carry save adder from a valid/ready operand
// stream and returns its result on a valid/ready result port.
// Operands are collected one per beat into a slot buffer that drives the
// adder inputs in parallel. Once a frame closes, the adder is given a fixed
// settle time before its Sum/Cout are registered and held for downstream.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  operand stream handshake
//   in_data, in_last   operand value, final operand of the frame
//   csa_ops            slot k on bits [k*WIDTH +: WIDTH], slot0 = adder input a
//   csa_sum, csa_cout  combinational result returned by the adder
//   out_valid/out_ready result handshake
//   out_sum, out_cout  registered adder result
//   out_count          number of real operands in the frame (1..NUM_OPS)

module csa_operand_sequencer #(
  parameter int WIDTH         = 16,
  parameter int NUM_OPS       = 9,
  parameter int SUM_WIDTH     = 20,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic [NUM_OPS*WIDTH-1:0] csa_ops,
  input  logic [SUM_WIDTH-1:0]     csa_sum,
  input  logic                     csa_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_WIDTH-1:0]     out_sum,
  output logic                     out_cout,
  output logic [3:0]               out_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    HOLD
  } state_e;

  state_e                           state_q, state_d;
  logic [NUM_OPS-1:0][WIDTH-1:0]    slots_q, slots_d;
  logic [3:0]                       idx_q, idx_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             out_valid_q, out_valid_d;
  logic [SUM_WIDTH-1:0]             out_sum_q, out_sum_d;
  logic                             out_cout_q, out_cout_d;
  logic [3:0]                       out_count_q, out_count_d;

  // Next-state logic. Slots only change on an accepted beat in LOAD or on
  // result acceptance in HOLD, so the adder inputs are stable through SETTLE
  // and HOLD. Clearing the slots on result acceptance makes the next short
  // frame zero-filled without any extra masking.
  always_comb begin
    state_d     = state_q;
    slots_d     = slots_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_count_d = out_count_q;
    in_ready    = 1'b0;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          slots_d[idx_q] = in_data;
          idx_d          = idx_q + 4'd1;
          // The frame closes on in_last or when the last slot is written.
          if (in_last || (idx_q == 4'(NUM_OPS - 1))) begin
            out_count_d = idx_q + 4'd1;
            cnt_d       = '0;
            state_d     = SETTLE;
          end
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          out_sum_d   = csa_sum;
          out_cout_d  = csa_cout;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          slots_d     = '0;
          idx_d       = '0;
          state_d     = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      slots_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      slots_q     <= slots_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_count_q <= out_count_d;
    end
  end

  assign csa_ops   = slots_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_count = out_count_q;

endmodule
